// File: rtl/counter4_pkg.sv
// Shared definitions for the counter4 checker: FSM states and the reference counter model.
package counter4_pkg;

  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {StSync, StTrack, StFault} state_t;

  // Reference model of counter4: clear dominates enable, wraps modulo 2^CNT_WIDTH.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic                 en,
                                                    input logic                 clr);
    if (clr) begin
      return '0;
    end else if (en) begin
      return cnt + 1'b1;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/counter4_checker_err_log.sv
// Error log: saturating error counter plus capture of the first error since clear.
module err_log #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             clr,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] act,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act
);

  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic             captured_q, captured_d;

  // Next-state: clear wins, otherwise count (saturating) and capture only the first hit.
  always_comb begin
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    act_d      = act_q;
    captured_d = captured_q;
    if (clr) begin
      cnt_d      = '0;
      exp_d      = '0;
      act_d      = '0;
      captured_d = 1'b0;
    end else if (hit) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (!captured_q) begin
        captured_d = 1'b1;
        exp_d      = exp;
        act_d      = act;
      end
    end
  end

  // Log registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      exp_q      <= '0;
      act_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      act_q      <= act_d;
      captured_q <= captured_d;
    end
  end

  assign err_cnt   = cnt_q;
  assign first_exp = exp_q;
  assign first_act = act_q;

endmodule

// File: rtl/counter4_checker.sv
// Cycle-accurate checker for a counter4 instance: predicts each count and flags deviations.
module counter4_checker
  import counter4_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_enable,
  input  logic             cnt_clear,
  input  logic [WIDTH-1:0] cnt_out,
  input  logic             err_clr,
  output logic             mismatch,
  output logic             fault,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic             pred_valid_q, pred_valid_d;
  logic             mismatch_q;
  logic             fault_q;
  logic             hit;

  // Prediction always follows the observed value, so one fault does not cascade.
  if (WIDTH == CNT_WIDTH) begin : g_pkg_model
    assign pred_d = cnt_next(cnt_out, cnt_enable, cnt_clear);
  end else begin : g_gen_model
    assign pred_d = cnt_clear ? '0 : (cnt_enable ? cnt_out + 1'b1 : cnt_out);
  end

  // FSM next-state and compare; err_clr discards any same-cycle mismatch.
  always_comb begin
    state_d      = state_q;
    pred_valid_d = 1'b1;
    hit          = 1'b0;
    if (err_clr) begin
      state_d      = StSync;
      pred_valid_d = 1'b0;
    end else begin
      hit = pred_valid_q && (cnt_out != pred_q);
      unique case (state_q)
        StSync:  state_d = StTrack;
        StTrack: if (hit) state_d = StFault;
        StFault: state_d = StFault;
        default: state_d = StSync;
      endcase
    end
  end

  // State, prediction and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StSync;
      pred_q       <= '0;
      pred_valid_q <= 1'b0;
      mismatch_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      pred_valid_q <= pred_valid_d;
      mismatch_q   <= hit;
      fault_q      <= (state_d == StFault);
    end
  end

  assign mismatch = mismatch_q;
  assign fault    = fault_q;

  err_log #(
    .WIDTH (WIDTH),
    .ERR_W (ERR_W)
  ) u_err_log (
    .clk       (clk),
    .reset     (reset),
    .hit       (hit),
    .clr       (err_clr),
    .exp       (pred_q),
    .act       (cnt_out),
    .err_cnt   (err_cnt),
    .first_exp (first_exp),
    .first_act (first_act)
  );

endmodule

// File: tb/tb_counter4_checker.sv
// Directed bench for counter4_checker: a live counter, injected faults, saturation,
// err_clr priority and asynchronous reset.
module tb_counter4_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, clr, eclr;
  logic       use_ctr;
  logic [3:0] man_out;
  logic [3:0] ctr_q;
  logic [3:0] cnt_out;

  logic       mismatch, fault;
  logic [7:0] err_cnt;
  logic [3:0] first_exp, first_act;
  logic       mismatch2, fault2;
  logic [1:0] err_cnt2;
  logic [3:0] first_exp2, first_act2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural counter4 used as the monitored device for the clean run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   ctr_q <= 4'd0;
    else if (clr) ctr_q <= 4'd0;
    else if (en)  ctr_q <= ctr_q + 4'd1;
  end

  assign cnt_out = use_ctr ? ctr_q : man_out;

  counter4_checker #(.WIDTH(4), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_enable (en),
    .cnt_clear  (clr),
    .cnt_out    (cnt_out),
    .err_clr    (eclr),
    .mismatch   (mismatch),
    .fault      (fault),
    .err_cnt    (err_cnt),
    .first_exp  (first_exp),
    .first_act  (first_act)
  );

  counter4_checker #(.WIDTH(4), .ERR_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .cnt_enable (en),
    .cnt_clear  (clr),
    .cnt_out    (cnt_out),
    .err_clr    (eclr),
    .mismatch   (mismatch2),
    .fault      (fault2),
    .err_cnt    (err_cnt2),
    .first_exp  (first_exp2),
    .first_act  (first_act2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic e, input logic c, input logic ec);
    man_out = v;
    en      = e;
    clr     = c;
    eclr    = ec;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; eclr = 1'b0; use_ctr = 1'b1; man_out = 4'd0;
    #12;
    chk("rst_mismatch", mismatch, 0);
    chk("rst_fault", fault, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_exp", first_exp, 0);
    chk("rst_first_act", first_act, 0);

    // Clean run over the 15->0 wrap.
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("run_mismatch", mismatch, 0);
    end
    chk("run_err_cnt", err_cnt, 0);
    chk("run_fault", fault, 0);

    // Counter now reads 4; take over cnt_out by hand.
    use_ctr = 1'b0;
    step(4'd4, 1, 0, 0);
    step(4'd5, 1, 0, 0);
    step(4'd7, 1, 0, 0);
    chk("err1_mismatch", mismatch, 1);
    chk("err1_fault", fault, 1);
    chk("err1_err_cnt", err_cnt, 1);
    chk("err1_first_exp", first_exp, 6);
    chk("err1_first_act", first_act, 7);
    step(4'd8, 1, 0, 0);
    chk("resync8_mismatch", mismatch, 0);
    step(4'd9, 1, 0, 0);
    chk("resync9_mismatch", mismatch, 0);
    chk("resync_err_cnt", err_cnt, 1);
    chk("resync_fault", fault, 1);

    // Three more errors while in FAULT.
    for (int i = 0; i < 3; i++) begin
      step(4'd0, 1, 0, 0);
      chk("fault_err_mismatch", mismatch, 1);
    end
    chk("fault_err_cnt", err_cnt, 4);
    chk("fault_first_exp", first_exp, 6);
    chk("fault_first_act", first_act, 7);
    chk("sat_err_cnt_4", err_cnt2, 3);

    // Clear dominates enable: 5 with both set predicts 0.
    for (int v = 1; v <= 4; v++) step(4'(v), 1, 0, 0);
    chk("pre_clr_mismatch", mismatch, 0);
    step(4'd5, 1, 1, 0);
    step(4'd0, 1, 0, 0);
    chk("clr_pass_mismatch", mismatch, 0);
    chk("clr_pass_err_cnt", err_cnt, 4);
    for (int v = 1; v <= 4; v++) step(4'(v), 1, 0, 0);
    step(4'd5, 1, 1, 0);
    step(4'd6, 1, 0, 0);
    chk("clr_flag_mismatch", mismatch, 1);
    chk("clr_flag_err_cnt", err_cnt, 5);
    chk("sat_err_cnt_5", err_cnt2, 3);

    // err_clr in the same cycle as a mismatch (pred is 7 here).
    step(4'd0, 1, 0, 1);
    chk("eclr_mismatch", mismatch, 0);
    chk("eclr_fault", fault, 0);
    chk("eclr_err_cnt", err_cnt, 0);
    chk("eclr_err_cnt_sat", err_cnt2, 0);
    chk("eclr_first_exp", first_exp, 0);
    chk("eclr_first_act", first_act, 0);
    step(4'd9, 1, 0, 0);
    chk("eclr_sync_mismatch", mismatch, 0);
    step(4'd3, 1, 0, 0);
    chk("eclr_resume_mismatch", mismatch, 1);
    chk("eclr_resume_err_cnt", err_cnt, 1);
    chk("eclr_resume_fault", fault, 1);
    chk("eclr_resume_first_exp", first_exp, 10);
    chk("eclr_resume_first_act", first_act, 3);

    // Asynchronous reset mid-cycle.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_mismatch", mismatch, 0);
    chk("arst_fault", fault, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_first_exp", first_exp, 0);
    chk("arst_first_act", first_act, 0);
    #2;
    reset = 1'b1;
    step(4'd9, 1, 0, 0);
    chk("arst_sync_mismatch", mismatch, 0);
    step(4'd2, 1, 0, 0);
    chk("arst_first_cmp_mismatch", mismatch, 1);
    chk("arst_first_cmp_exp", first_exp, 10);
    chk("arst_first_cmp_act", first_act, 2);
    chk("arst_first_cmp_err_cnt", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter4_checker.md
# counter4_checker

Cycle-accurate checker for the `counter4` up-counter interface: samples the counter's enable, synchronous clear and count output every clock, predicts the next count, and flags any deviation. It sits on the consumer side of the counter bus in the KX1 servo firmware, beside any counter instance whose output feeds timing logic. Errors are counted, the first failure is captured for readback, and a sticky fault state persists until it is explicitly cleared.

## Interface

- `WIDTH`, 4: count width; must match the monitored counter.
- `ERR_W`, 8: error-counter width.
- `clk`  in  1  system clock; all sampling on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cnt_enable`  in  1  enable driven to the monitored counter.
- `cnt_clear`  in  1  synchronous, active-high clear driven to the monitored counter.
- `cnt_out`  in  WIDTH  monitored counter output.
- `err_clr`  in  1  synchronous clear of the fault state and error log.
- `mismatch`  out  1  one-cycle pulse per detected error.
- `fault`  out  1  sticky; high in FAULT.
- `err_cnt`  out  ERR_W  saturating error count.
- `first_exp`  out  WIDTH  expected value at the first error.
- `first_act`  out  WIDTH  actual value at the first error.

## Operation

- Counter model: `next = cnt_clear ? 0 : cnt_enable ? cnt_out+1 : cnt_out`, computed modulo 2^WIDTH (15+1 → 0 at WIDTH=4). Clear dominates enable.
- Internal registers: `pred` (WIDTH bits) and `pred_valid`. On every edge, `pred` loads `next` computed from the current inputs. Prediction always resynchronises to the actual value, so one fault does not cascade into repeated errors.
- States:
  - SYNC: entered on reset or `err_clr`. No compare. Loads `pred`, then goes to TRACK on the next edge.
  - TRACK: compares `cnt_out` with `pred` every edge.
    - On mismatch: pulse `mismatch`; increment `err_cnt`; capture `first_exp`=`pred` and `first_act`=`cnt_out`; go to FAULT.
  - FAULT: continues comparing. Each mismatch pulses `mismatch` and increments `err_cnt`. `first_*` stay frozen. Leaves only via `err_clr` (to SYNC) or reset.
- `err_cnt` saturates at 2^ERR_W−1 and never wraps.
- `err_clr` has priority over a mismatch in the same cycle. That mismatch is discarded: no pulse, no count.
- `cnt_clear` alone never changes checker state. It only changes the prediction.

## Timing

- Reset values: `mismatch`=0, `fault`=0, `err_cnt`=0, `first_exp`=0, `first_act`=0, `pred`=0; state=SYNC.
- Reset deassertion: first compare at the second rising edge after release (one edge in SYNC).
- Latency: a bad `cnt_out` sampled at edge k gives `mismatch`=1 during cycle k→k+1; `err_cnt`, `fault` and `first_*` update at edge k.
- `err_clr` sampled at edge k:
  - `fault`, `err_cnt` and `first_*` read 0 after edge k.
  - Compares resume at edge k+2.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous), independent of `clk`.
- Combinational path: inputs → `pred` only. All outputs are registered.

## Structure

- Shared package `counter4_pkg`:
  - state enum {SYNC, TRACK, FAULT};
  - `CNT_WIDTH`=4 default;
  - a function `cnt_next(cnt, en, clr)` implementing the counter model, so RTL and bench share one definition.
- One sub-module is natural: `err_log`. It holds the saturating `err_cnt` and the first-error capture registers, taking `hit`, `clr`, `exp` and `act` as inputs.
- FSM and prediction stay in the top module.

## Test plan

- Drive a real `counter4`: reset, then `cnt_enable`=1 for 20 cycles including the 15→0 wrap → `mismatch` never asserts, `err_cnt`=0, `fault`=0.
- Force `cnt_out`=7 where `pred`=6 → one-cycle `mismatch`, `fault`=1, `err_cnt`=1, `first_exp`=6, `first_act`=7. Follow with a correct sequence 8,9 → no further errors.
- In FAULT, inject 3 more errors → `err_cnt`=4; `first_exp`/`first_act` still 6/7.
- Assert `cnt_enable`=1 and `cnt_clear`=1 together with `cnt_out`=5 → next `pred`=0. A counter output of 0 passes; an output of 6 is flagged.
- With ERR_W=2, inject 5 errors → `err_cnt` holds at 3. Then `err_clr` in the same cycle as an error → `err_cnt`=0, `fault`=0, no `mismatch` pulse.
- Pulse `reset` low mid-count, asynchronous to `clk` → all outputs 0 immediately. First compare occurs at the second edge after release.
